// File: rtl/id_ex_latch_pkg.sv
// Shared constants for the MIPS decode/execute boundary: widths, register $0,
// ALU-op encodings and the execute-stage control bundle.
package id_ex_latch_pkg;

   localparam int LEN           = 32;
   localparam int NB_ADDR       = 5;
   localparam int NB_ALU_OP     = 2;
   localparam int NB_BUBBLE_CNT = 16;

   localparam logic [NB_ADDR-1:0] REG_ZERO = '0;

   typedef enum logic [NB_ALU_OP-1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SUB   = 2'b01,
      ALU_OP_RTYPE = 2'b10,
      ALU_OP_IMM   = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic reg_dst;
      logic alu_src;
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
      logic branch;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_latch_hazard_detection.sv
// Load-use hazard compare: a load in EX whose destination (rt) is a source of
// the instruction in ID. Writes to $0 are never a dependency.
module hazard_detection
   import id_ex_latch_pkg::*;
#(
   parameter int NB_addr = NB_ADDR
) (
   input  logic               i_ex_valid,
   input  logic               i_ex_mem_read,
   input  logic [NB_addr-1:0] i_ex_rt,
   input  logic               i_id_valid,
   input  logic [NB_addr-1:0] i_id_rs,
   input  logic [NB_addr-1:0] i_id_rt,
   input  logic               i_id_uses_rt,
   output logic               o_hazard
);

   logic w_rs_match;
   logic w_rt_match;

   assign w_rs_match = (i_ex_rt == i_id_rs);
   assign w_rt_match = i_id_uses_rt & (i_ex_rt == i_id_rt);

   assign o_hazard = i_ex_valid & i_ex_mem_read & (i_ex_rt != NB_addr'(REG_ZERO))
                   & i_id_valid & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush,
// debug-step freeze and a saturating count of inserted bubbles.
module id_ex_latch
   import id_ex_latch_pkg::*;
#(
   parameter int len           = LEN,
   parameter int NB_addr       = NB_ADDR,
   parameter int NB_alu_op     = NB_ALU_OP,
   parameter int NB_bubble_cnt = NB_BUBBLE_CNT
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_enable,
   input  logic                     i_flush,
   input  logic                     i_valid,
   input  logic [len-1:0]           i_pc,
   input  logic [len-1:0]           i_reg_1,
   input  logic [len-1:0]           i_reg_2,
   input  logic [len-1:0]           i_sign_extend,
   input  logic [NB_addr-1:0]       i_rs,
   input  logic [NB_addr-1:0]       i_rt,
   input  logic [NB_addr-1:0]       i_rd,
   input  logic                     i_uses_rt,
   input  logic                     i_reg_dst,
   input  logic                     i_alu_src,
   input  logic                     i_mem_read,
   input  logic                     i_mem_write,
   input  logic                     i_reg_write,
   input  logic                     i_mem_to_reg,
   input  logic                     i_branch,
   input  logic [NB_alu_op-1:0]     i_alu_op,
   output logic                     o_valid,
   output logic [len-1:0]           o_pc,
   output logic [len-1:0]           o_reg_1,
   output logic [len-1:0]           o_reg_2,
   output logic [len-1:0]           o_sign_extend,
   output logic [NB_addr-1:0]       o_rs,
   output logic [NB_addr-1:0]       o_rt,
   output logic [NB_addr-1:0]       o_rd,
   output logic                     o_reg_dst,
   output logic                     o_alu_src,
   output logic                     o_mem_read,
   output logic                     o_mem_write,
   output logic                     o_reg_write,
   output logic                     o_mem_to_reg,
   output logic                     o_branch,
   output logic [NB_alu_op-1:0]     o_alu_op,
   output logic                     o_stall,
   output logic [NB_bubble_cnt-1:0] o_bubble_count
);

   logic                     r_valid;
   logic [len-1:0]           r_pc;
   logic [len-1:0]           r_reg_1;
   logic [len-1:0]           r_reg_2;
   logic [len-1:0]           r_sign_extend;
   logic [NB_addr-1:0]       r_rs;
   logic [NB_addr-1:0]       r_rt;
   logic [NB_addr-1:0]       r_rd;
   ctrl_t                    r_ctrl;
   logic [NB_alu_op-1:0]     r_alu_op;
   logic [NB_bubble_cnt-1:0] r_bubble_count;

   ctrl_t w_ctrl_in;
   logic  w_hazard;
   logic  w_bubble;
   logic  w_count_inc;

   assign w_ctrl_in = '{reg_dst:    i_reg_dst,
                        alu_src:    i_alu_src,
                        mem_read:   i_mem_read,
                        mem_write:  i_mem_write,
                        reg_write:  i_reg_write,
                        mem_to_reg: i_mem_to_reg,
                        branch:     i_branch};

   hazard_detection #(
      .NB_addr (NB_addr)
   ) u_hazard_detection (
      .i_ex_valid    (r_valid),
      .i_ex_mem_read (r_ctrl.mem_read),
      .i_ex_rt       (r_rt),
      .i_id_valid    (i_valid),
      .i_id_rs       (i_rs),
      .i_id_rt       (i_rt),
      .i_id_uses_rt  (i_uses_rt),
      .o_hazard      (w_hazard)
   );

   // A flush already kills the ID instruction, so it neither stalls nor counts.
   assign o_stall     = w_hazard & i_enable & ~i_flush & ~i_rst;
   assign w_bubble    = i_flush | w_hazard;
   assign w_count_inc = w_hazard & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid        <= 1'b0;
         r_pc           <= '0;
         r_reg_1        <= '0;
         r_reg_2        <= '0;
         r_sign_extend  <= '0;
         r_rs           <= '0;
         r_rt           <= '0;
         r_rd           <= '0;
         r_ctrl         <= CTRL_NOP;
         r_alu_op       <= '0;
         r_bubble_count <= '0;
      end else if (i_enable) begin
         r_pc          <= i_pc;
         r_reg_1       <= i_reg_1;
         r_reg_2       <= i_reg_2;
         r_sign_extend <= i_sign_extend;
         r_rs          <= i_rs;
         r_rt          <= i_rt;
         r_rd          <= i_rd;
         if (w_bubble) begin
            r_valid  <= 1'b0;
            r_ctrl   <= CTRL_NOP;
            r_alu_op <= '0;
            if (w_count_inc && (r_bubble_count != {NB_bubble_cnt{1'b1}}))
               r_bubble_count <= r_bubble_count + NB_bubble_cnt'(1);
         end else begin
            r_valid  <= i_valid;
            r_ctrl   <= w_ctrl_in;
            r_alu_op <= i_alu_op;
         end
      end
   end

   assign o_valid        = r_valid;
   assign o_pc           = r_pc;
   assign o_reg_1        = r_reg_1;
   assign o_reg_2        = r_reg_2;
   assign o_sign_extend  = r_sign_extend;
   assign o_rs           = r_rs;
   assign o_rt           = r_rt;
   assign o_rd           = r_rd;
   assign o_reg_dst      = r_ctrl.reg_dst;
   assign o_alu_src      = r_ctrl.alu_src;
   assign o_mem_read     = r_ctrl.mem_read;
   assign o_mem_write    = r_ctrl.mem_write;
   assign o_reg_write    = r_ctrl.reg_write;
   assign o_mem_to_reg   = r_ctrl.mem_to_reg;
   assign o_branch       = r_ctrl.branch;
   assign o_alu_op       = r_alu_op;
   assign o_bubble_count = r_bubble_count;

endmodule
